// File: rtl/rs232_resp_pkg.sv
// Shared types and constants for the RS-232 register responder.
package rs232_resp_pkg;

  localparam int unsigned BYTE_W              = 8;
  localparam int unsigned IDX_W               = 7;
  localparam int unsigned READ_FLAG           = 7;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 500000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GET_DATA  = 2'd1,
    SEND_ADDR = 2'd2,
    SEND_DATA = 2'd3
  } resp_state_e;

  // Address byte of a frame: read flag on top, register index below.
  typedef struct packed {
    logic             rd;
    logic [IDX_W-1:0] idx;
  } addr_byte_t;

endpackage

// File: rtl/rs232_resp_timeout.sv
// Inter-byte timeout counter: counts while running, clears on request,
// flags expiry combinationally on the last counted cycle.
module rs232_resp_timeout
  import rs232_resp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_c = run_i && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next count: clear wins, otherwise advance while running, holding at expiry.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rs232_reg_responder.sv
// Register-bank responder behind a byte UART: address byte (bit7 = read),
// optional data byte, then echoes address and data/readback byte.
// Optional inter-byte timeout in GET_DATA: define RESP_TIMEOUT_EN.
module rs232_reg_responder
  import rs232_resp_pkg::*;
#(
  parameter int unsigned NREGS       = 16,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic                CLK_50MHZ,
  input  logic                RST,
  input  logic                RX_VALID,
  input  logic [BYTE_W-1:0]   RX_DATA,
  output logic                TX_VALID,
  output logic [BYTE_W-1:0]   TX_DATA,
  input  logic                TX_READY,
  output logic [NREGS*8-1:0]  REGS,
  output logic                BUSY,
  output logic                DROP
);

  resp_state_e       state_q, state_d;
  addr_byte_t        addr_q, addr_d;
  logic [BYTE_W-1:0] resp_q, resp_d;
  logic              tx_valid_q, tx_valid_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic [BYTE_W-1:0] regs_q [NREGS];
  logic [BYTE_W-1:0] rd_byte_c;
  logic              wr_en_c;
  logic              drop_c;
  logic              expire_c;

`ifdef RESP_TIMEOUT_EN
  rs232_resp_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk      (CLK_50MHZ),
    .rst_n    (RST),
    .run_i    (state_q == GET_DATA),
    .clear_i  (state_q != GET_DATA),
    .expire_c (expire_c)
  );
`else
  // GET_DATA waits forever; the timeout parameter has no consumer here.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign expire_c           = 1'b0;
`endif

  // Readback mux; indices outside the bank read as zero.
  always_comb begin
    rd_byte_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RX_DATA[IDX_W-1:0] == IDX_W'(i)) begin
        rd_byte_c = regs_q[i];
      end
    end
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    resp_d     = resp_q;
    wr_en_c    = 1'b0;
    drop_c     = 1'b0;
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    busy_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (RX_VALID) begin
          addr_d = addr_byte_t'(RX_DATA);
          if (RX_DATA[READ_FLAG]) begin
            resp_d  = rd_byte_c;
            state_d = SEND_ADDR;
          end else begin
            state_d = GET_DATA;
          end
        end
      end
      GET_DATA: begin
        if (RX_VALID) begin
          resp_d  = RX_DATA;
          wr_en_c = 1'b1;
          state_d = SEND_ADDR;
        end else if (expire_c) begin
          state_d = IDLE;
        end
      end
      SEND_ADDR: begin
        drop_c = RX_VALID;
        if (TX_READY && tx_valid_q) begin
          state_d = SEND_DATA;
        end
      end
      SEND_DATA: begin
        drop_c = RX_VALID;
        if (TX_READY && tx_valid_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    unique case (state_d)
      SEND_ADDR: begin
        tx_valid_d = 1'b1;
        tx_data_d  = addr_d;
      end
      SEND_DATA: begin
        tx_valid_d = 1'b1;
        tx_data_d  = resp_d;
      end
      default: begin
        tx_valid_d = 1'b0;
        tx_data_d  = '0;
      end
    endcase
  end

  // State and frame registers.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      resp_q     <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      resp_q     <= resp_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
    end
  end

  // Register bank; writes to indices outside the bank match no entry.
  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en_c && (addr_q.idx == IDX_W'(i))) begin
          regs_q[i] <= RX_DATA;
        end
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regs_flat
    assign REGS[g*8 +: 8] = regs_q[g];
  end

  assign TX_VALID = tx_valid_q;
  assign TX_DATA  = tx_data_q;
  assign BUSY     = busy_q;
  assign DROP     = drop_c;

endmodule

// File: doc/rs232_reg_responder.md
RS232_REG_RESPONDER -- requirements
Module: rs232_reg_responder

Interface
REQ-001 The block SHALL have parameter NREGS, default 16, meaning the number of 8-bit registers (1..128).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 500000, meaning the inter-byte timeout in clock cycles (10 ms at 50 MHz).
REQ-003 The block SHALL have port CLK_50MHZ  input  1  main clock, all logic on its rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port RX_VALID  input  1  one-cycle pulse when the UART has received a byte.
REQ-006 The block SHALL have port RX_DATA  input  8  received byte, valid only when RX_VALID=1.
REQ-007 The block SHALL have port TX_VALID  output  1  a response byte is offered to the UART.
REQ-008 The block SHALL have port TX_DATA  output  8  response byte.
REQ-009 The block SHALL have port TX_READY  input  1  UART accepts the byte on this edge when TX_VALID=1.
REQ-010 The block SHALL have port REGS  output  NREGS*8  flat register bank, register i at bits [8i+7:8i].
REQ-011 The block SHALL have port BUSY  output  1  high in any state other than IDLE.
REQ-012 The block SHALL have port DROP  output  1  one-cycle pulse when an RX byte is discarded.

Function
REQ-013 Frame: byte0 = address byte, with bit7 = read flag and bits[6:0] = register index; a write frame is followed by byte1 = data.
REQ-014 FSM states SHALL be IDLE, GET_DATA, SEND_ADDR, SEND_DATA.
REQ-015 IDLE + RX_VALID: the address byte SHALL be latched; bit7=1 -> SEND_ADDR, bit7=0 -> GET_DATA.
REQ-016 GET_DATA + RX_VALID: the data byte SHALL be latched and written to the register on the same edge if the index < NREGS; the state SHALL then go to SEND_ADDR.
REQ-017 SEND_ADDR SHALL present the latched address byte, and SEND_DATA SHALL present the response byte; each state SHALL hold TX_DATA stable with TX_VALID=1 until the edge where TX_READY=1, then advance (SEND_DATA -> IDLE).
REQ-018 Response byte: for a write, the echoed data byte; for a read, the register value sampled on entry to SEND_ADDR.
REQ-019 Index >= NREGS: the write SHALL be ignored and a read SHALL return 8'h00; the frame SHALL otherwise be handled normally.
REQ-020 An RX_VALID pulse in SEND_ADDR or SEND_DATA SHALL be discarded, with DROP pulsing on the same cycle.
REQ-021 TX_VALID SHALL be registered; the first byte SHALL be offered one cycle after the frame-completing RX_VALID.
REQ-022 TX_READY arriving in the same cycle as entry into a SEND state SHALL NOT be honoured; acceptance requires TX_VALID=1 at that edge.

Reset
REQ-023 While RST=0: state = IDLE, TX_VALID = 0, TX_DATA = 0, REGS = all zero, BUSY = 0, DROP = 0, timeout counter = 0.
REQ-024 Reset asserted mid-frame or mid-transmit SHALL abort immediately, with no partial register write.

Configuration
REQ-025 With RESP_TIMEOUT_EN defined, a counter SHALL run in GET_DATA and return the state to IDLE after TIMEOUT_CYC cycles without RX_VALID, with no write; RX_VALID on the expiry cycle SHALL win.
REQ-026 Without RESP_TIMEOUT_EN, GET_DATA SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-027 Package rs232_resp_pkg SHALL hold the state encoding, the READ_FLAG bit position (7) and the default TIMEOUT_CYC.
REQ-028 Sub-module rs232_resp_timeout (counter with clear and expire) SHALL be instantiated only under RESP_TIMEOUT_EN.

Verification
REQ-029 Write frame 8'h0E, 8'h03 -> REGS[0x0E] = 8'h03; TX sends 8'h0E then 8'h03; BUSY returns to 0.
REQ-030 Read frame 8'h8E after the write -> TX sends 8'h8E then 8'h03; REGS unchanged.
REQ-031 Write 8'h40, 8'hAA with NREGS=16 -> REGS all unchanged; echo 8'h40, 8'hAA; read 8'hC0 -> 8'hC0, 8'h00.
REQ-032 TX_READY held low for 100 cycles -> TX_VALID/TX_DATA stable; an RX byte in this window -> DROP pulse, and the frame is not restarted.
REQ-033 With RESP_TIMEOUT_EN and TIMEOUT_CYC=100, send 8'h05 then nothing -> IDLE after 100 cycles, REGS[5] unchanged, no TX.
REQ-034 Assert RST during GET_DATA and during SEND_DATA -> all outputs are at reset values, and the next frame works normally.
